// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32I data-memory responder with wait states, lane masking and load extension
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Counter preload; the zero-wait configuration never enters WAIT.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_funct3;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        go_resp;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_funct3;

    logic [31:0] off;
    logic [1:0]  lane;
    logic [AW-1:0] idx;
    logic        out_of_range;
    logic        bad_funct3;
    logic        misaligned;
    logic        acc_err;

    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] load_ext;
    logic [31:0] resp_data;

    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic        do_write;

    assign accept = req_valid && req_ready;

    // The response is computed on the edge entering RESP: straight from the
    // request inputs when there are no wait states, otherwise from the latch.
    assign go_resp = ((state == S_IDLE) && accept && (WAIT_STATES == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd0));

    // Select which copy of the request fields drives decode and the RAM port.
    always_comb begin
        if (state == S_IDLE) begin
            cur_we     = req_we;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
            cur_funct3 = req_funct3;
        end else begin
            cur_we     = lat_we;
            cur_addr   = lat_addr;
            cur_wdata  = lat_wdata;
            cur_funct3 = lat_funct3;
        end
    end

    // Address decode and error classification for the current access.
    always_comb begin
        off          = cur_addr - BASE_ADDR;
        lane         = off[1:0];
        idx          = off[AW+1:2];
        out_of_range = (cur_addr < BASE_ADDR) ||
                       ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS));
        if (cur_we) begin
            bad_funct3 = cur_funct3[2] || (cur_funct3[1:0] == 2'b11);
        end else begin
            bad_funct3 = (cur_funct3[1:0] == 2'b11) || (cur_funct3 == 3'b110);
        end
        misaligned   = ((cur_funct3[1:0] == 2'b01) && lane[0]) ||
                       ((cur_funct3[1:0] == 2'b10) && (lane != 2'b00));
        acc_err      = out_of_range || bad_funct3 || misaligned;
    end

    // Load path: pick the addressed lane and extend it according to funct3.
    always_comb begin
        rd_word  = mem[idx];
        rd_shift = rd_word >> {lane, 3'b000};
        case (cur_funct3)
            3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_ext = rd_word;
            3'b100:  load_ext = {24'd0, rd_shift[7:0]};
            3'b101:  load_ext = {16'd0, rd_shift[15:0]};
            default: load_ext = 32'd0;
        endcase
        resp_data = (acc_err || cur_we) ? 32'd0 : load_ext;
    end

    // Store path: byte enables and replicated data for the addressed lanes.
    always_comb begin
        case (cur_funct3[1:0])
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
        case (cur_funct3[1:0])
            2'b00:   wdata_rep = {4{cur_wdata[7:0]}};
            2'b01:   wdata_rep = {2{cur_wdata[15:0]}};
            default: wdata_rep = cur_wdata;
        endcase
    end

    // The registered rsp_err is the decode result of the latched store, so an
    // erroring store never touches the array.
    assign do_write = (state == S_RESP) && lat_we && !rsp_err;

    // Control FSM, request latch and registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_funct3 <= 3'd0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            if (go_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= resp_data;
            end
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        lat_we     <= req_we;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        lat_funct3 <= req_funct3;
                        req_ready  <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

    // RAM array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

endmodule
